// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad matrix scanner.
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEY_W = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  function automatic logic [KEY_W-1:0] key_encode(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Keypad bus: matrix lines plus the decoded key outputs.
interface keypad_matrix_scanner_if;
  import keypad_pkg::*;

  logic [COLS-1:0]  col_in;
  logic [ROWS-1:0]  row_out;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;

  modport master (input col_in, output row_out, key_code, key_valid, key_held);
  modport slave  (output col_in, input row_out, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_matrix_scanner_row_driver.sv
// Row dwell divider: drives one active-low row at a time and flags the
// sample cycle (last cycle of each dwell) and the end of each 4-row frame.
module keypad_row_driver
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 2500
) (
  input  logic            clock_10Mhz,
  input  logic            reset,
  output logic [ROWS-1:0] row_out,
  output logic [1:0]      row_idx,
  output logic            sample,
  output logic            frame_end
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div;

  assign sample    = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_end = sample && (row_idx == 2'd3);

  // Row advances in the same cycle its columns are sampled, so each row
  // gets the full dwell minus one cycle to settle through the synchronizer.
  always_ff @(posedge clock_10Mhz or posedge reset) begin
    if (reset) begin
      div     <= '0;
      row_idx <= 2'd0;
      row_out <= 4'b1110;
    end else if (sample) begin
      div     <= '0;
      row_idx <= row_idx + 2'd1;
      row_out <= ~(ROWS'(1) << (row_idx + 2'd1));
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: synchronizer, per-frame priority encoder, debounce FSM.
// Optional auto-repeat while a key is held is enabled by KEYPAD_REPEAT_EN.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 2500,
  parameter int DEBOUNCE_FRAMES = 8,
  parameter int REPEAT_FRAMES   = 200
) (
  input  logic                    clock_10Mhz,
  input  logic                    reset,
  keypad_matrix_scanner_if.master bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

  logic [ROWS-1:0]  row_out;
  logic [1:0]       row_idx;
  logic             sample;
  logic             frame_end;

  logic [COLS-1:0]  col_s1, col_s2, pressed;
  logic             row_hit;
  logic [1:0]       row_col;
  logic             cand_now;

  logic             acc_hit, acc_cand;
  logic [KEY_W-1:0] acc_key;
  logic             eval_hit, eval_cand;
  logic [KEY_W-1:0] eval_key;

  state_t           state, state_n;
  logic [KEY_W-1:0] cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [KEY_W-1:0] key_code, key_code_n;
  logic             key_valid, key_valid_n;
  logic             key_held, key_held_n;

  keypad_row_driver #(.SCAN_DIV(SCAN_DIV)) u_row_driver (
    .clock_10Mhz (clock_10Mhz),
    .reset       (reset),
    .row_out     (row_out),
    .row_idx     (row_idx),
    .sample      (sample),
    .frame_end   (frame_end)
  );

  always_ff @(posedge clock_10Mhz or posedge reset) begin
    if (reset) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= bus.col_in;
      col_s2 <= col_s1;
    end
  end

  assign pressed = ~col_s2;
  assign row_hit = |pressed;

  always_comb begin
    row_col = 2'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (pressed[c]) row_col = 2'(c);
    end
  end

  assign cand_now = (row_idx == cand[3:2]) && pressed[cand[1:0]];

  // Rows arrive in ascending order, so the first row with a hit wins priority.
  always_ff @(posedge clock_10Mhz or posedge reset) begin
    if (reset) begin
      acc_hit  <= 1'b0;
      acc_cand <= 1'b0;
      acc_key  <= '0;
    end else if (frame_end) begin
      acc_hit  <= 1'b0;
      acc_cand <= 1'b0;
      acc_key  <= '0;
    end else if (sample) begin
      if (!acc_hit && row_hit) acc_key <= key_encode(row_idx, row_col);
      acc_hit  <= acc_hit | row_hit;
      acc_cand <= acc_cand | cand_now;
    end
  end

  assign eval_hit  = acc_hit | row_hit;
  assign eval_key  = acc_hit ? acc_key : key_encode(row_idx, row_col);
  assign eval_cand = acc_cand | cand_now;
  assign cnt_inc   = cnt + 1'b1;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] rep_cnt, rep_n, rep_inc;
  assign rep_inc = rep_cnt + 1'b1;
`endif

  always_ff @(posedge clock_10Mhz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_n;
`endif
    end
  end

  // Decisions happen only at frame evaluation; key_valid is a registered pulse.
  always_comb begin
    state_n     = state;
    cand_n      = cand;
    cnt_n       = cnt;
    key_code_n  = key_code;
    key_valid_n = 1'b0;
    key_held_n  = key_held;
`ifdef KEYPAD_REPEAT_EN
    rep_n       = (state == RELEASE) ? '0 : rep_cnt;
`endif
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (eval_hit) begin
            cand_n = eval_key;
            cnt_n  = CNT_W'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              state_n     = HELD;
              key_code_n  = eval_key;
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_n       = '0;
`endif
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (eval_hit && eval_key == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
              state_n     = HELD;
              key_code_n  = cand;
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_n       = '0;
`endif
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        HELD: begin
          if (!eval_cand) begin
            cnt_n = CNT_W'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              state_n    = IDLE;
              key_held_n = 1'b0;
            end else begin
              state_n = RELEASE;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_inc == REP_W'(REPEAT_FRAMES)) begin
            rep_n       = '0;
            key_valid_n = 1'b1;
          end else begin
            rep_n = rep_inc;
          end
`endif
        end
        RELEASE: begin
          if (eval_cand) begin
            state_n = HELD;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
              state_n    = IDLE;
              key_held_n = 1'b0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.row_out   = row_out;
  assign bus.key_code  = key_code;
  assign bus.key_valid = key_valid;
  assign bus.key_held  = key_held;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: key-matrix model, vector table and pulse scoreboard.
module tb_keypad_matrix_scanner;
  import keypad_pkg::*;

  localparam int FRAME = 16;
  localparam int DF    = 3;
  localparam int RF    = 4;

  logic clock_10Mhz = 1'b0;
  logic reset;
  logic [15:0] keys;
  int cyc;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] code;
    int         at_cyc;
  } pulse_t;
  pulse_t exp_q[$];

  typedef struct {
    logic [15:0] keys;
    int          frames;
    bit          pulse;
    logic [3:0]  code;
  } vec_t;
  vec_t vecs[5];

  keypad_matrix_scanner_if bus();

  keypad_matrix_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_FRAMES(DF),
    .REPEAT_FRAMES(RF)
  ) dut (
    .clock_10Mhz (clock_10Mhz),
    .reset       (reset),
    .bus         (bus)
  );

  always #50 clock_10Mhz = ~clock_10Mhz;

  // A pressed key shorts its column low whenever its row is driven.
  always_comb begin
    bus.col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !bus.row_out[r]) bus.col_in[c] = 1'b0;
  end

  always @(posedge clock_10Mhz or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clock_10Mhz) begin
    if (!reset && bus.key_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected key_valid: cycle %0d code %0d, expected none", cyc, bus.key_code);
      end else begin
        pulse_t p;
        p = exp_q.pop_front();
        check_output("pulse key_code", bus.key_code, p.code);
        check_output("pulse cycle", cyc, p.at_cyc);
      end
    end
  end

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clock_10Mhz);
  endtask

  // Called at a frame boundary; predicts accept and (if enabled) repeat pulses.
  task automatic push_press(input logic [3:0] code, input int frames);
    int f;
    f = cyc / FRAME;
    if (frames >= DF) exp_q.push_back('{code, FRAME * (f + DF)});
`ifdef KEYPAD_REPEAT_EN
    for (int k = DF + RF; k <= frames; k += RF) exp_q.push_back('{code, FRAME * (f + k)});
`endif
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    keys = v.keys;
    if (v.pulse) push_press(v.code, v.frames);
    wait_frames(v.frames);
    check_output({tag, " held while pressed"}, bus.key_held, v.pulse);
    check_output({tag, " key_code"}, bus.key_code, v.code);
    keys = 16'h0;
    wait_frames(2);
    check_output({tag, " held after 2 clear"}, bus.key_held, v.pulse);
    wait_frames(1);
    check_output({tag, " held after 3 clear"}, bus.key_held, 1'b0);
    wait_frames(1);
  endtask

  initial begin
    vecs[0] = '{16'h0040, 2,  1'b0, 4'd0};
    vecs[1] = '{16'h0040, 6,  1'b1, 4'd6};
    vecs[2] = '{16'h0240, 4,  1'b1, 4'd6};
    vecs[3] = '{16'h8000, 4,  1'b1, 4'd15};
    vecs[4] = '{16'h0008, 14, 1'b1, 4'd3};

    keys  = 16'h0;
    reset = 1'b1;
    repeat (2) @(negedge clock_10Mhz);
    check_output("reset row_out", bus.row_out, 4'b1110);
    check_output("reset key_code", bus.key_code, 4'd0);
    check_output("reset key_valid", bus.key_valid, 1'b0);
    check_output("reset key_held", bus.key_held, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < FRAME; i++) begin
      logic [3:0] exp_row;
      exp_row = ~(4'b0001 << (i / 4));
      check_output("row scan", bus.row_out, exp_row);
      @(negedge clock_10Mhz);
    end

    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Short release glitch while HELD must not re-trigger.
    keys = 16'h8000;
    push_press(4'd15, 4);
    wait_frames(4);
    keys = 16'h0;
    wait_frames(1);
    keys = 16'h8000;
    wait_frames(3);
    check_output("glitch held", bus.key_held, 1'b1);
    check_output("glitch key_code", bus.key_code, 4'd15);
    keys = 16'h0;
    wait_frames(4);
    check_output("glitch released", bus.key_held, 1'b0);

    // Reset mid-debounce aborts; a fresh full press is then needed.
    keys = 16'h0040;
    wait_frames(2);
    reset = 1'b1;
    #1;
    check_output("mid reset key_code", bus.key_code, 4'd0);
    check_output("mid reset key_valid", bus.key_valid, 1'b0);
    check_output("mid reset row_out", bus.row_out, 4'b1110);
    @(negedge clock_10Mhz);
    @(negedge clock_10Mhz);
    check_output("mid reset no pending pulse", exp_q.size(), 0);
    reset = 1'b0;
    push_press(4'd6, 6);
    wait_frames(6);
    check_output("post reset held", bus.key_held, 1'b1);
    check_output("post reset key_code", bus.key_code, 4'd6);
    keys = 16'h0;
    wait_frames(4);
    check_output("post reset released", bus.key_held, 1'b0);

    wait_frames(1);
    check_output("missing pulses", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
